// File: rtl/sccb_cfg_pkg.sv
// Shared definitions for the OV7670 SCCB configuration sequencer:
// table markers, FSM encoding and millisecond-to-cycle conversion.
package sccb_cfg_pkg;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    localparam int unsigned ACCEPT_TIMEOUT = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_ACCEPT,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_NEXT,
        ST_FINISH
    } cfg_state_t;

    function automatic logic [31:0] ms_to_cycles(
        input int unsigned clk_freq,
        input int unsigned ms
    );
        logic [31:0] per_ms;
        per_ms = 32'(clk_freq / 1000);
        return per_ms * 32'(ms);
    endfunction

endpackage

// File: rtl/sccb_config_sequencer_ms_timer.sv
// Loadable 32-bit down-counter shared by the power-up and delay waits.
// expired is high whenever the count has reached zero.
module ms_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        tick,
    output logic        expired
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 32'd1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the OV7670 init table and hands each register write to the
// SCCB engine, honouring delay and end-of-table markers.
module sccb_config_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int          ROM_AW     = 8,
    parameter int unsigned POWERUP_MS = 1,
    parameter int unsigned DELAY_MS   = 10,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              sccb_ready,
    output logic              sccb_start,
    output logic [7:0]        sccb_address,
    output logic [7:0]        sccb_data,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic [ROM_AW-1:0] cfg_count
);

    localparam logic [31:0] PWRUP_CYC = ms_to_cycles(CLK_FREQ, POWERUP_MS);
    localparam logic [31:0] DELAY_CYC = ms_to_cycles(CLK_FREQ, DELAY_MS);
    localparam logic [ROM_AW-1:0] LAST_ADDR = '1;
    localparam logic [3:0] ACC_LAST = 4'(ACCEPT_TIMEOUT - 1);

    cfg_state_t state, state_nxt;

    logic        auto_pend;
    logic [3:0]  acc_cnt;
    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_tick;
    logic        tmr_exp;

    logic run_init;
    logic latch;
    logic issue;
    logic count_inc;
    logic addr_inc;
    logic finish;
    logic acc_clr;
    logic acc_inc;

    ms_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_init  = 1'b0;
        latch     = 1'b0;
        issue     = 1'b0;
        count_inc = 1'b0;
        addr_inc  = 1'b0;
        finish    = 1'b0;
        acc_clr   = 1'b0;
        acc_inc   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_tick  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (auto_pend || cfg_start) begin
                    run_init  = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = PWRUP_CYC;
                    state_nxt = ST_PWRUP;
                end
            end
            ST_PWRUP: begin
                tmr_tick = 1'b1;
                if (tmr_exp) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (rom_data == CFG_END) begin
                    state_nxt = ST_FINISH;
                end else if (rom_data == CFG_DELAY) begin
                    tmr_load  = 1'b1;
                    tmr_val   = DELAY_CYC;
                    state_nxt = ST_DELAY;
                end else begin
                    latch     = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (sccb_ready) begin
                    issue     = 1'b1;
                    acc_clr   = 1'b1;
                    state_nxt = ST_ACCEPT;
                end
            end
            // Engine that never acknowledges gets the same entry re-issued.
            ST_ACCEPT: begin
                if (!sccb_ready) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (acc_cnt == ACC_LAST) begin
                    state_nxt = ST_SEND;
                end else begin
                    acc_inc = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (sccb_ready) begin
                    count_inc = 1'b1;
                    state_nxt = ST_NEXT;
                end
            end
            ST_DELAY: begin
                tmr_tick = 1'b1;
                if (tmr_exp) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (rom_addr == LAST_ADDR) begin
                    state_nxt = ST_FINISH;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FINISH: begin
                finish    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_pend    <= AUTO_START;
            rom_addr     <= '0;
            sccb_start   <= 1'b0;
            sccb_address <= '0;
            sccb_data    <= '0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_count    <= '0;
            acc_cnt      <= '0;
        end else begin
            sccb_start <= issue;
            if (run_init) begin
                auto_pend <= 1'b0;
                rom_addr  <= '0;
                cfg_count <= '0;
                cfg_done  <= 1'b0;
                cfg_busy  <= 1'b1;
            end
            if (latch) begin
                sccb_address <= rom_data[15:8];
                sccb_data    <= rom_data[7:0];
            end
            if (count_inc) begin
                cfg_count <= cfg_count + 1'b1;
            end
            if (addr_inc) begin
                rom_addr <= rom_addr + 1'b1;
            end
            if (finish) begin
                cfg_busy <= 1'b0;
                cfg_done <= 1'b1;
            end
            if (acc_clr) begin
                acc_cnt <= '0;
            end else if (acc_inc) begin
                acc_cnt <= acc_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer with behavioural ROMs and
// SCCB engine models (ready drops after start, low for 50 cycles).
module tb_sccb_config_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        n_cmp++;
        if (act < min) begin
            n_bad++;
            $display("FAIL %s: got %0d, want >= %0d", name, act, min);
        end
    endtask

    // ---------------- instance A: ROM_AW=8 ----------------
    logic        rst_a = 1'b0;
    logic        start_a = 1'b0;
    logic [7:0]  addr_a;
    logic [15:0] data_a = '0;
    logic        rdy_a = 1'b1;
    logic        go_a;
    logic [7:0]  sa_a, sd_a;
    logic        busy_a, done_a;
    logic [7:0]  cnt_a;

    sccb_config_sequencer #(
        .CLK_FREQ(10000), .ROM_AW(8), .POWERUP_MS(1),
        .DELAY_MS(10), .AUTO_START(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_a), .cfg_start(start_a),
        .rom_addr(addr_a), .rom_data(data_a), .sccb_ready(rdy_a),
        .sccb_start(go_a), .sccb_address(sa_a), .sccb_data(sd_a),
        .cfg_busy(busy_a), .cfg_done(done_a), .cfg_count(cnt_a)
    );

    logic [15:0] mem_a [256];
    always @(posedge clk) data_a <= mem_a[addr_a];

    bit          stuck = 1'b0;
    int          hold_a = 0;
    int          wr_n = 0;
    int          bad_start = 0;
    logic [15:0] wr_log [64];
    int          wr_st [64];
    int          wr_dn [64];

    always @(posedge clk) begin
        if (go_a) begin
            if (!rdy_a) bad_start++;
            if (wr_n < 64) begin
                wr_log[wr_n] = {sa_a, sd_a};
                wr_st[wr_n] = cyc;
            end
            wr_n++;
            if (!stuck) begin
                rdy_a  <= 1'b0;
                hold_a <= 50;
            end
        end else if (hold_a > 0) begin
            hold_a <= hold_a - 1;
            if (hold_a == 1) begin
                rdy_a <= 1'b1;
                if (wr_n > 0 && wr_n <= 64) wr_dn[wr_n-1] = cyc;
            end
        end
    end

    // ---------------- instance B: ROM_AW=2 ----------------
    logic        rst_b = 1'b0;
    logic [1:0]  addr_b;
    logic [15:0] data_b = '0;
    logic        rdy_b = 1'b1;
    logic        go_b;
    logic [7:0]  sa_b, sd_b;
    logic        busy_b, done_b;
    logic [1:0]  cnt_b;

    sccb_config_sequencer #(
        .CLK_FREQ(10000), .ROM_AW(2), .POWERUP_MS(1),
        .DELAY_MS(10), .AUTO_START(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .cfg_start(1'b0),
        .rom_addr(addr_b), .rom_data(data_b), .sccb_ready(rdy_b),
        .sccb_start(go_b), .sccb_address(sa_b), .sccb_data(sd_b),
        .cfg_busy(busy_b), .cfg_done(done_b), .cfg_count(cnt_b)
    );

    logic [15:0] mem_b [4];
    always @(posedge clk) data_b <= mem_b[addr_b];

    int          hold_b = 0;
    int          wrb_n = 0;
    logic [15:0] wrb_log [16];
    bit          seen_nz_b = 1'b0;
    int          wrap_b = 0;

    always @(posedge clk) begin
        if (go_b) begin
            if (wrb_n < 16) wrb_log[wrb_n] = {sa_b, sd_b};
            wrb_n++;
            rdy_b  <= 1'b0;
            hold_b <= 50;
        end else if (hold_b > 0) begin
            hold_b <= hold_b - 1;
            if (hold_b == 1) rdy_b <= 1'b1;
        end
        if (rst_b && busy_b) begin
            if (addr_b != 2'd0) seen_nz_b = 1'b1;
            else if (seen_nz_b) wrap_b++;
        end
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [7:0][15:0] tbl;
        logic [3:0][15:0] wr;
        logic [7:0]       n_wr;
        logic [31:0]      gap;
    } vec_t;

    vec_t v [4];
    int   base;
    int   bbase;
    int   rel;

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b0;
        base  = wr_n;
        bbase = bad_start;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        rel   = cyc;
    endtask

    task automatic load_a(input int i);
        for (int j = 0; j < 256; j++) mem_a[j] = 16'hFFFF;
        for (int j = 0; j < 8; j++) mem_a[j] = v[i].tbl[j];
    endtask

    task automatic wait_done_a(input int lim, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (done_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr_a(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (wr_n - base >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input int i);
        bit ok;
        load_a(i);
        reset_a();
        wait_done_a(3000, ok);
        chk($sformatf("vec%0d_finished", i), 32'(ok), 32'd1);
        chk($sformatf("vec%0d_nwr", i), 32'(wr_n - base), 32'(v[i].n_wr));
        for (int k = 0; k < int'(v[i].n_wr); k++)
            chk($sformatf("vec%0d_wr%0d", i, k), 32'(wr_log[base+k]),
                32'(v[i].wr[k]));
        chk($sformatf("vec%0d_count", i), 32'(cnt_a), 32'(v[i].n_wr));
        chk($sformatf("vec%0d_busy", i), 32'(busy_a), 32'd0);
        chk($sformatf("vec%0d_done", i), 32'(done_a), 32'd1);
        if (v[i].n_wr > 0)
            chk_ge($sformatf("vec%0d_first_latency", i),
                   wr_st[base] - rel, 11);
        if (v[i].gap > 0)
            chk_ge($sformatf("vec%0d_delay_gap", i),
                   wr_st[base+1] - wr_dn[base], int'(v[i].gap));
        chk($sformatf("vec%0d_no_start_while_busy", i),
            32'(bad_start - bbase), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int b2;

        for (int i = 0; i < 4; i++) begin
            v[i].tbl  = {8{16'hFFFF}};
            v[i].wr   = '0;
            v[i].n_wr = '0;
            v[i].gap  = '0;
        end
        v[0].tbl[0] = 16'h1280; v[0].tbl[1] = 16'h1204;
        v[0].wr[0]  = 16'h1280; v[0].wr[1]  = 16'h1204;
        v[0].n_wr   = 8'd2;
        v[1].tbl[0] = 16'h1180; v[1].tbl[1] = 16'hFFF0;
        v[1].tbl[2] = 16'h3A04;
        v[1].wr[0]  = 16'h1180; v[1].wr[1]  = 16'h3A04;
        v[1].n_wr   = 8'd2;     v[1].gap    = 32'd100;
        v[3].tbl[0] = 16'h0000; v[3].tbl[1] = 16'hFFF0;
        v[3].tbl[2] = 16'hFFF0; v[3].tbl[3] = 16'h5555;
        v[3].wr[0]  = 16'h0000; v[3].wr[1]  = 16'h5555;
        v[3].n_wr   = 8'd2;     v[3].gap    = 32'd200;

        mem_b[0] = 16'h0101; mem_b[1] = 16'h0202;
        mem_b[2] = 16'h0303; mem_b[3] = 16'h0404;

        load_a(0);
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {go_a, busy_a, done_a, cnt_a, addr_a, sa_a, sd_a}, 32'd0);

        for (int i = 0; i < 4; i++) run_vec(i);

        // reset during the second write's WAIT_DONE
        load_a(0);
        reset_a();
        wait_wr_a(2, 1000, ok);
        chk("rst_mid_reached_wr2", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        chk("rst_mid_pre_busy", {31'd0, busy_a}, 32'd1);
        chk("rst_mid_pre_ready_low", {31'd0, rdy_a}, 32'd0);
        #3 rst_a = 1'b0;
        #1;
        chk("rst_mid_start_low", {31'd0, go_a}, 32'd0);
        chk("rst_mid_outputs",
            {go_a, busy_a, done_a, cnt_a, addr_a, sa_a, sd_a}, 32'd0);
        base  = wr_n;
        bbase = bad_start;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        wait_done_a(2000, ok);
        chk("rst_rerun_finished", 32'(ok), 32'd1);
        chk("rst_rerun_no_start_while_busy", 32'(bad_start - bbase), 32'd0);
        chk("rst_rerun_nwr", 32'(wr_n - base), 32'd2);
        chk("rst_rerun_wr0", 32'(wr_log[base]), 32'h1280);
        chk("rst_rerun_wr1", 32'(wr_log[base+1]), 32'h1204);
        chk("rst_rerun_count", 32'(cnt_a), 32'd2);

        // cfg_start while busy ignored, after done reruns
        reset_a();
        repeat (20) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(2000, ok);
        chk("start_busy_finished", 32'(ok), 32'd1);
        repeat (40) @(negedge clk);
        chk("start_busy_one_run", 32'(wr_n - base), 32'd2);
        chk("start_busy_done_held", {31'd0, done_a}, 32'd1);
        b2 = wr_n;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("restart_done_cleared", {31'd0, done_a}, 32'd0);
        chk("restart_busy", {31'd0, busy_a}, 32'd1);
        chk("restart_count_cleared", 32'(cnt_a), 32'd0);
        wait_done_a(2000, ok);
        chk("restart_finished", 32'(ok), 32'd1);
        chk("restart_nwr", 32'(wr_n - b2), 32'd2);
        chk("restart_wr0", 32'(wr_log[b2]), 32'h1280);
        chk("restart_wr1", 32'(wr_log[b2+1]), 32'h1204);
        chk("restart_count", 32'(cnt_a), 32'd2);

        // engine never acknowledges
        stuck = 1'b1;
        reset_a();
        wait_wr_a(5, 600, ok);
        chk("stuck_reissued", 32'(ok), 32'd1);
        for (int k = 1; k < 5; k++) begin
            chk_ge($sformatf("stuck_interval%0d", k),
                   wr_st[base+k] - wr_st[base+k-1], 17);
            chk($sformatf("stuck_entry%0d", k), 32'(wr_log[base+k]),
                32'h1280);
        end
        chk("stuck_count", 32'(cnt_a), 32'd0);
        chk("stuck_busy", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        rst_a = 1'b0;
        stuck = 1'b0;

        // ROM_AW=2 table with no end marker
        @(negedge clk);
        rst_b = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done_b) begin
                ok = 1'b1;
                break;
            end
        end
        chk("aw2_finished", 32'(ok), 32'd1);
        chk("aw2_nwr", 32'(wrb_n), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("aw2_wr%0d", k), 32'(wrb_log[k]),
                32'(mem_b[k]));
        chk("aw2_no_wrap", 32'(wrap_b), 32'd0);
        chk("aw2_last_addr", 32'(addr_b), 32'd3);
        chk("aw2_busy", {31'd0, busy_b}, 32'd0);
        repeat (60) @(negedge clk);
        chk("aw2_no_extra", 32'(wrb_n), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
